// File: rtl/operand_fwd_stage.sv
// Operand-fetch stage: selects each source from the register file, a forwarding
// path, PC, immediate or zero, and registers the operation behind a valid/ready handshake.
module operand_fwd_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 3,
  parameter int unsigned REGW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           sel_a,
  input  logic [1:0]           sel_b,
  input  logic [REGW-1:0]      rega_addr,
  input  logic [REGW-1:0]      regb_addr,
  input  logic [XLEN-1:0]      rega_data,
  input  logic [XLEN-1:0]      regb_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*REGW-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      operand_a,
  output logic [XLEN-1:0]      operand_b,
  output logic [XLEN-1:0]      out_pc,
  output logic [15:0]          stall_count
);

  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_PC   = 2'd1;
  localparam logic [1:0] SEL_IMM  = 2'd2;

  logic [XLEN-1:0] reg_a, reg_b;
  logic [XLEN-1:0] opa_d, opb_d;
  logic            pend_a, pend_b;
  logic            hazard;
  logic            capture;
  logic [15:0]     stall_q;

  // Walk oldest to youngest so the lowest-index (youngest) match wins.
  always_comb begin
    reg_a  = rega_data;
    reg_b  = regb_data;
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int unsigned k = 0; k < NFWD; k++) begin
      if (fwd_valid[NFWD-1-k] && (fwd_addr[(NFWD-1-k)*REGW +: REGW] == rega_addr)) begin
        reg_a  = fwd_data[(NFWD-1-k)*XLEN +: XLEN];
        pend_a = fwd_pending[NFWD-1-k];
      end
      if (fwd_valid[NFWD-1-k] && (fwd_addr[(NFWD-1-k)*REGW +: REGW] == regb_addr)) begin
        reg_b  = fwd_data[(NFWD-1-k)*XLEN +: XLEN];
        pend_b = fwd_pending[NFWD-1-k];
      end
    end
    if (rega_addr == '0) begin
      reg_a  = '0;
      pend_a = 1'b0;
    end
    if (regb_addr == '0) begin
      reg_b  = '0;
      pend_b = 1'b0;
    end
  end

  always_comb begin
    case (sel_a)
      SEL_REG: opa_d = reg_a;
      SEL_PC:  opa_d = pc;
      SEL_IMM: opa_d = imm;
      default: opa_d = '0;
    endcase
    case (sel_b)
      SEL_REG: opb_d = reg_b;
      SEL_PC:  opb_d = pc;
      SEL_IMM: opb_d = imm;
      default: opb_d = '0;
    endcase
  end

  assign hazard   = in_valid && (((sel_a == SEL_REG) && pend_a) || ((sel_b == SEL_REG) && pend_b));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      operand_a <= opa_d;
      operand_b <= opb_d;
      out_pc    <= pc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage: driver pushes expected operations to a
// queue, a monitor pops and compares each one the DUT hands off.
module tb_operand_fwd_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NFWD = 3;
  localparam int unsigned REGW = 5;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           sel_a, sel_b;
  logic [REGW-1:0]      rega_addr, regb_addr;
  logic [XLEN-1:0]      rega_data, regb_data, imm, pc;
  logic [NFWD-1:0]      fwd_valid, fwd_pending;
  logic [NFWD*REGW-1:0] fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      operand_a, operand_b, out_pc;
  logic [15:0]          stall_count;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  operand_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel_a(sel_a), .sel_b(sel_b), .rega_addr(rega_addr), .regb_addr(regb_addr),
    .rega_data(rega_data), .regb_data(regb_data), .imm(imm), .pc(pc),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .out_pc(out_pc),
    .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 2 time units after each rising edge; checks sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_fwd();
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic p,
                         input logic [REGW-1:0] a, input logic [XLEN-1:0] d);
    fwd_valid[i]              = v;
    fwd_pending[i]            = p;
    fwd_addr[i*REGW +: REGW]  = a;
    fwd_data[i*XLEN +: XLEN]  = d;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    sel_a     = 2'd3;
    sel_b     = 2'd3;
    rega_addr = '0;
    regb_addr = '0;
    rega_data = '0;
    regb_data = '0;
    imm       = '0;
    pc        = '0;
    flush     = 1'b0;
    clr_fwd();
  endtask

  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] p);
    exp_t e;
    e.a = a;
    e.b = b;
    e.p = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted hand-off must match the oldest expected operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got a=0x%0h b=0x%0h pc=0x%0h expected none",
                   operand_a, operand_b, out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("mon_operand_a", operand_a, e.a);
          chk("mon_operand_b", operand_b, e.b);
          chk("mon_out_pc", out_pc, e.p);
        end
      end
    end
  end

  initial begin
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;

    // Youngest of two matching sources wins.
    idle();
    in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd2;
    rega_addr = 5'd5; rega_data = 32'h1111; imm = 32'h55; pc = 32'h100;
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
    set_fwd(2, 1'b1, 1'b0, 5'd5, 32'hBBBB);
    push(32'hAAAA, 32'h55, 32'h100);
    @(negedge clk);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // x0 reads zero even when a source targets it; B forwards from source 1.
    idle();
    in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd0;
    rega_addr = 5'd0; rega_data = 32'hDEAD; regb_addr = 5'd3; regb_data = 32'h3333; pc = 32'h104;
    set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h1234);
    set_fwd(1, 1'b1, 1'b0, 5'd3, 32'hC3C3);
    push(32'h0, 32'hC3C3, 32'h104);
    @(negedge clk);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // PC/ZERO selects ignore a pending match on the register indices.
    idle();
    in_valid = 1'b1; sel_a = 2'd1; sel_b = 2'd3;
    rega_addr = 5'd5; regb_addr = 5'd5; pc = 32'h200;
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h5555);
    push(32'h200, 32'h0, 32'h200);
    @(negedge clk);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // Pending older source shadowed by a non-pending younger one.
    idle();
    in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd0;
    rega_addr = 5'd9; rega_data = 32'h1; regb_addr = 5'd10; regb_data = 32'hABCD; pc = 32'h300;
    set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h9999);
    set_fwd(1, 1'b1, 1'b1, 5'd9, 32'h8888);
    push(32'h9999, 32'hABCD, 32'h300);
    @(negedge clk);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    idle();
    cyc();
    @(negedge clk);
    chk("t4_stall", {16'd0, stall_count}, 32'd0);
    cyc();

    // Load-use stall for three cycles, capture on the fourth edge.
    idle();
    in_valid = 1'b1; sel_a = 2'd2; sel_b = 2'd0;
    imm = 32'h44; regb_addr = 5'd7; regb_data = 32'h0707; pc = 32'h400;
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h7777);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    fwd_pending = '0;
    push(32'h44, 32'h7777, 32'h400);
    @(negedge clk);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_stall", {16'd0, stall_count}, 32'd3);
    cyc();
    idle();
    cyc();

    // Back-pressure holds outputs; release accepts the waiting op on the same edge.
    out_ready = 1'b0;
    in_valid = 1'b1; sel_a = 2'd2; sel_b = 2'd1; imm = 32'h600; pc = 32'h604;
    push(32'h600, 32'h604, 32'h604);
    cyc();
    imm = 32'h700; pc = 32'h704;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_hold_a", operand_a, 32'h600);
      chk("t6_hold_b", operand_b, 32'h604);
      chk("t6_hold_pc", out_pc, 32'h604);
      cyc();
    end
    out_ready = 1'b1;
    push(32'h700, 32'h704, 32'h704);
    @(negedge clk);
    chk("t6_release_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_new_a", operand_a, 32'h700);
    cyc();

    // Flush kills the held op and blocks the incoming one.
    out_ready = 1'b0;
    in_valid = 1'b1; sel_a = 2'd2; sel_b = 2'd3; imm = 32'h800; pc = 32'h800;
    cyc();
    out_ready = 1'b1; flush = 1'b1; imm = 32'h900; pc = 32'h900;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t7_flush_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("t7_no_capture", {31'd0, out_valid}, 32'd0);
    cyc();

    // Reset wins over flush and capture.
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 32'hA00; pc = 32'hA04;
    cyc();
    rst = 1'b1; flush = 1'b1; imm = 32'hB00; pc = 32'hB04;
    cyc();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t8_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t8_rst_a", operand_a, 32'd0);
    chk("t8_rst_b", operand_b, 32'd0);
    chk("t8_rst_pc", out_pc, 32'd0);
    chk("t8_rst_stall", {16'd0, stall_count}, 32'd0);
    cyc();
    out_ready = 1'b1;

    // Saturation: preload the counter just below its ceiling.
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    @(negedge clk);
    chk("t9_preload", {16'd0, stall_count}, 32'h0000FFFE);
    cyc();
    idle();
    in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd3; rega_addr = 5'd4;
    set_fwd(1, 1'b1, 1'b1, 5'd4, 32'h4444);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("t9_saturate", {16'd0, stall_count}, 32'h0000FFFF);
    end
    cyc();
    idle();
    cyc();
    cyc();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_fwd_stage.md
OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/data width.
REQ-002 SHALL have parameter NFWD, default 3, number of forwarding sources; index 0 youngest (EX), NFWD-1 oldest (WB).
REQ-003 SHALL have parameter REGW, default 5, register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  decode stage presents an operation.
REQ-007 SHALL have port in_ready  output  1  stage accepts the operation this cycle.
REQ-008 SHALL have port sel_a  input  2  0=RA, 1=PC, 2=IMM, 3=ZERO.
REQ-009 SHALL have port sel_b  input  2  0=RB, 1=PC, 2=IMM, 3=ZERO.
REQ-010 SHALL have ports rega_addr, regb_addr  input  REGW  source register indices.
REQ-011 SHALL have ports rega_data, regb_data, imm, pc  input  XLEN  register file data, immediate, decode PC.
REQ-012 SHALL have port fwd_valid  input  NFWD  source i holds a live register write.
REQ-013 SHALL have port fwd_pending  input  NFWD  source i result not yet available (e.g. load in flight).
REQ-014 SHALL have port fwd_addr  input  NFWD*REGW  destination index of source i (slice i).
REQ-015 SHALL have port fwd_data  input  NFWD*XLEN  result of source i (slice i).
REQ-016 SHALL have port flush  input  1  kill captured and incoming operation.
REQ-017 SHALL have port out_valid  output  1  operand_a/operand_b hold a valid operation.
REQ-018 SHALL have port out_ready  input  1  execute stage consumes the operation.
REQ-019 SHALL have ports operand_a, operand_b, out_pc  output  XLEN  registered operands and PC.
REQ-020 SHALL have port stall_count  output  16  number of hazard-stall cycles since reset.

Function
REQ-021 SHALL resolve operand A when sel_a=RA (B when sel_b=RB) by forwarding: match i = fwd_valid[i] and fwd_addr[i]==rega_addr and rega_addr!=0.
REQ-022 SHALL select the lowest-index matching source; no match -> register file data; address 0 -> value 0 regardless of forwarding.
REQ-023 SHALL use pc, imm or 0 for PC, IMM, ZERO selects; these never forward and never raise a hazard.
REQ-024 SHALL raise hazard when in_valid and the selected (lowest-index) match for any register-selected operand has fwd_pending set; a pending older source shadowed by a younger non-pending match SHALL NOT raise hazard.
REQ-025 SHALL drive in_ready = !hazard and (!out_valid or out_ready); combinational, no dependence on in_valid except via hazard.
REQ-026 SHALL capture operands, pc into operand_a/operand_b/out_pc and set out_valid on a clock edge with in_valid and in_ready; latency exactly 1 cycle.
REQ-027 SHALL clear out_valid on a clock edge with out_ready and out_valid and no capture.
REQ-028 SHALL hold operand_a, operand_b, out_pc and out_valid unchanged while out_valid and !out_ready (back-pressure).
REQ-029 SHALL, on flush, clear out_valid at the next edge and suppress capture that cycle; flush has priority over capture and hold.
REQ-030 SHALL increment stall_count by 1 on each edge where in_valid and hazard; saturate at 16'hFFFF; no wrap.
REQ-031 SHALL leave operand_a/operand_b/out_pc values unspecified-but-stable when out_valid is 0 (no clearing required except reset).

Reset
REQ-032 SHALL, on rst high at a clock edge, set out_valid=0, operand_a=0, operand_b=0, out_pc=0, stall_count=0; rst overrides flush, capture and count.
REQ-033 SHALL drop any operation in flight when rst asserts mid-operation; first capture possible on the edge after rst deasserts.

Verification
REQ-034 SHALL check: rega_addr=5, fwd0 {valid,addr=5,data=0xAAAA}, fwd2 {valid,addr=5,data=0xBBBB}, sel_a=RA -> operand_a=0xAAAA one cycle later.
REQ-035 SHALL check: rega_addr=0, fwd0 {valid,addr=0,data=0x1234} -> operand_a=0.
REQ-036 SHALL check: regb_addr=7, fwd0 {valid,pending,addr=7}, in_valid for 3 cycles then pending drops -> in_ready=0 for 3 cycles, stall_count=3, capture on 4th edge.
REQ-037 SHALL check: out_valid=1, out_ready=0 for 4 cycles with new in_valid -> outputs constant, in_ready=0; out_ready=1 -> new op captured same edge.
REQ-038 SHALL check: flush and in_valid same cycle, out_valid=1 -> out_valid=0 next cycle, no capture; rst with flush and in_valid -> all outputs 0.
REQ-039 SHALL check: stall_count preloaded to 0xFFFE via 3 hazard cycles beyond -> stall_count stays 0xFFFF.
